// File: rtl/gpio_input_irq.sv
// GPIO input block: two-flop synchroniser, per-pin debounce, rise/fall edge capture into a
// W1C status register, and a masked level IRQ.
module gpio_input_irq #(
    parameter int unsigned BITS            = 16,
    parameter int unsigned ADDRESS_BITS    = 8,
    parameter int unsigned CLK_FREQ        = 12000000,
    parameter int unsigned N_INPUTS        = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_BITS-1:0] ADDRESS,
    input  logic [BITS-1:0]         DATA_IN,
    output logic [BITS-1:0]         DATA_OUT,
    input  logic                    WR,
    input  logic [N_INPUTS-1:0]     INPUT_PINS,
    output logic                    IRQ
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [ADDRESS_BITS-1:0] AddrState  = ADDRESS_BITS'(0);
    localparam logic [ADDRESS_BITS-1:0] AddrRiseEn = ADDRESS_BITS'(1);
    localparam logic [ADDRESS_BITS-1:0] AddrFallEn = ADDRESS_BITS'(2);
    localparam logic [ADDRESS_BITS-1:0] AddrStatus = ADDRESS_BITS'(3);
    localparam logic [ADDRESS_BITS-1:0] AddrMask   = ADDRESS_BITS'(4);
    localparam logic [ADDRESS_BITS-1:0] AddrRaw    = ADDRESS_BITS'(5);

    // CLK_FREQ only documents the clock the DEBOUNCE_CYCLES value was chosen for.
    if (CLK_FREQ == 0) begin : g_clk_freq_unset
    end

    logic [N_INPUTS-1:0] sync_a_q, sync_b_q;
    logic [N_INPUTS-1:0] deb_q, deb_d;
    logic [N_INPUTS-1:0] rise_en_q, fall_en_q, mask_q;
    logic [N_INPUTS-1:0] status_q, status_d;
    logic [N_INPUTS-1:0] rise, fall;
    logic [N_INPUTS-1:0] wr_data;
    logic [CntW-1:0]     cnt_q [N_INPUTS];
    logic [CntW-1:0]     cnt_d [N_INPUTS];
    logic                wr_rise_en, wr_fall_en, wr_status, wr_mask;
    logic                unused_data_in;

    assign wr_data        = DATA_IN[N_INPUTS-1:0];
    assign unused_data_in = ^DATA_IN;

    assign wr_rise_en = WR && (ADDRESS == AddrRiseEn);
    assign wr_fall_en = WR && (ADDRESS == AddrFallEn);
    assign wr_status  = WR && (ADDRESS == AddrStatus);
    assign wr_mask    = WR && (ADDRESS == AddrMask);

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(N_INPUTS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_b_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                deb_d[i] = sync_b_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        rise = deb_d & ~deb_q & rise_en_q;
        fall = ~deb_d & deb_q & fall_en_q;

        // Clear first, then OR in new events so a same-cycle event survives the W1C.
        status_d = status_q;
        if (wr_status) begin
            status_d = status_d & ~wr_data;
        end
        status_d = status_d | rise | fall;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            deb_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            for (int i = 0; i < int'(N_INPUTS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_a_q <= INPUT_PINS;
            sync_b_q <= sync_a_q;
            deb_q    <= deb_d;
            status_q <= status_d;
            for (int i = 0; i < int'(N_INPUTS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (wr_rise_en) begin
                rise_en_q <= wr_data;
            end
            if (wr_fall_en) begin
                fall_en_q <= wr_data;
            end
            if (wr_mask) begin
                mask_q <= wr_data;
            end
        end
    end

    always_comb begin
        DATA_OUT = '0;
        case (ADDRESS)
            AddrState:  DATA_OUT = BITS'(deb_q);
            AddrRiseEn: DATA_OUT = BITS'(rise_en_q);
            AddrFallEn: DATA_OUT = BITS'(fall_en_q);
            AddrStatus: DATA_OUT = BITS'(status_q);
            AddrMask:   DATA_OUT = BITS'(mask_q);
            AddrRaw:    DATA_OUT = BITS'(sync_b_q);
            default:    DATA_OUT = '0;
        endcase
    end

    assign IRQ = |(status_q & mask_q);

endmodule

// File: tb/tb_gpio_input_irq.sv
// Self-checking bench for gpio_input_irq with a short debounce (D=4).
module tb_gpio_input_irq;

    localparam int unsigned D = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  ADDRESS = '0;
    logic [15:0] DATA_IN = '0;
    logic [15:0] DATA_OUT;
    logic        WR = 1'b0;
    logic [5:0]  INPUT_PINS = '0;
    logic        IRQ;

    gpio_input_irq #(
        .BITS            (16),
        .ADDRESS_BITS    (8),
        .CLK_FREQ        (12000000),
        .N_INPUTS        (6),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ADDRESS    (ADDRESS),
        .DATA_IN    (DATA_IN),
        .DATA_OUT   (DATA_OUT),
        .WR         (WR),
        .INPUT_PINS (INPUT_PINS),
        .IRQ        (IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        irq;
    } exp_t;

    typedef struct {
        string       name;
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic        exp_irq;
    } vec_t;

    exp_t sb[$];
    vec_t rst_vec[7];
    vec_t rb_vec[6];
    int   checks = 0;
    int   errors = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        ADDRESS = a;
        DATA_IN = d;
        WR      = 1'b1;
        @(posedge CLK);
        #1;
        WR = 1'b0;
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (DATA_OUT !== e.data || IRQ !== e.irq) begin
            errors++;
            $display("FAIL %s: addr=%02h got data=%04h irq=%b, expected data=%04h irq=%b",
                     e.name, e.addr, DATA_OUT, IRQ, e.data, e.irq);
        end
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [15:0] d,
                      input logic irq);
        exp_t e;
        WR      = 1'b0;
        ADDRESS = a;
        e.name  = name;
        e.addr  = a;
        e.data  = d;
        e.irq   = irq;
        sb.push_back(e);
        #1;
        compare_front();
    endtask

    task automatic apply_vec(input vec_t v);
        if (v.wr) wr(v.addr, v.wdata);
        rd(v.name, v.addr, v.exp_data, v.exp_irq);
    endtask

    initial begin
        rst_vec[0] = '{"rst_state",   1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0};
        rst_vec[1] = '{"rst_rise_en", 1'b0, 8'h01, 16'h0000, 16'h0000, 1'b0};
        rst_vec[2] = '{"rst_fall_en", 1'b0, 8'h02, 16'h0000, 16'h0000, 1'b0};
        rst_vec[3] = '{"rst_status",  1'b0, 8'h03, 16'h0000, 16'h0000, 1'b0};
        rst_vec[4] = '{"rst_mask",    1'b0, 8'h04, 16'h0000, 16'h0000, 1'b0};
        rst_vec[5] = '{"rst_raw",     1'b0, 8'h05, 16'h0000, 16'h0000, 1'b0};
        rst_vec[6] = '{"rst_unmapped",1'b0, 8'h06, 16'h0000, 16'h0000, 1'b0};

        rb_vec[0] = '{"rb_rise_en",  1'b1, 8'h01, 16'hFFFF, 16'h003F, 1'b1};
        rb_vec[1] = '{"rb_fall_en",  1'b1, 8'h02, 16'hFFFF, 16'h003F, 1'b1};
        rb_vec[2] = '{"rb_mask",     1'b1, 8'h04, 16'hFFFF, 16'h003F, 1'b1};
        rb_vec[3] = '{"rb_state_ro", 1'b1, 8'h00, 16'hFFFF, 16'h0021, 1'b1};
        rb_vec[4] = '{"rb_raw_ro",   1'b1, 8'h05, 16'hFFFF, 16'h0021, 1'b1};
        rb_vec[5] = '{"rb_unmapped", 1'b1, 8'h06, 16'hFFFF, 16'h0000, 1'b1};

        // Reset with all pins high, then release.
        INPUT_PINS = 6'h3F;
        RST        = 1'b1;
        tick(2);
        for (int i = 0; i < 7; i++) apply_vec(rst_vec[i]);
        RST = 1'b0;
        tick(1 + D);
        rd("rst_state_early", 8'h00, 16'h0000, 1'b0);
        tick(1);
        rd("rst_state_deb", 8'h00, 16'h003F, 1'b0);
        rd("rst_status_deb", 8'h03, 16'h0000, 1'b0);

        // Rising edge latency on pin0.
        INPUT_PINS = 6'h00;
        tick(D + 2);
        rd("deb_pre_state", 8'h00, 16'h0000, 1'b0);
        wr(8'h01, 16'h0001);
        wr(8'h04, 16'h0001);
        INPUT_PINS = 6'h01;
        tick(1);
        rd("deb_raw_e0", 8'h05, 16'h0000, 1'b0);
        tick(1);
        rd("deb_raw_e1", 8'h05, 16'h0001, 1'b0);
        rd("deb_state_e1", 8'h00, 16'h0000, 1'b0);
        tick(3);
        rd("deb_state_e4", 8'h00, 16'h0000, 1'b0);
        rd("deb_status_e4", 8'h03, 16'h0000, 1'b0);
        tick(1);
        rd("deb_state_e5", 8'h00, 16'h0001, 1'b1);
        rd("deb_status_e5", 8'h03, 16'h0001, 1'b1);

        // Glitch on pin2 lasting D-1 cycles.
        wr(8'h01, 16'h0005);
        wr(8'h04, 16'h0005);
        wr(8'h03, 16'h0001);
        rd("gl_status_clr", 8'h03, 16'h0000, 1'b0);
        INPUT_PINS = 6'h05;
        tick(2);
        rd("gl_raw_high", 8'h05, 16'h0005, 1'b0);
        tick(1);
        INPUT_PINS = 6'h01;
        tick(2);
        rd("gl_raw_low", 8'h05, 16'h0001, 1'b0);
        tick(D);
        rd("gl_state", 8'h00, 16'h0001, 1'b0);
        rd("gl_status", 8'h03, 16'h0000, 1'b0);

        // Falling edge on pin5, masked, then unmasked.
        wr(8'h02, 16'h0020);
        wr(8'h04, 16'h0000);
        INPUT_PINS = 6'h21;
        tick(D + 2);
        rd("fall_state_hi", 8'h00, 16'h0021, 1'b0);
        rd("fall_status_none", 8'h03, 16'h0000, 1'b0);
        INPUT_PINS = 6'h01;
        tick(D + 2);
        rd("fall_state_lo", 8'h00, 16'h0001, 1'b0);
        rd("fall_status_masked", 8'h03, 16'h0020, 1'b0);
        wr(8'h04, 16'h0020);
        rd("fall_irq_unmasked", 8'h03, 16'h0020, 1'b1);

        // W1C behaviour, including a clear colliding with a new event.
        INPUT_PINS = 6'h00;
        tick(D + 2);
        rd("w1c_pin0_fall", 8'h03, 16'h0020, 1'b1);
        INPUT_PINS = 6'h01;
        tick(D + 2);
        rd("w1c_status_21", 8'h03, 16'h0021, 1'b1);
        wr(8'h03, 16'h0001);
        rd("w1c_clear_bit0", 8'h03, 16'h0020, 1'b1);
        wr(8'h03, 16'h0020);
        rd("w1c_clear_bit5", 8'h03, 16'h0000, 1'b0);
        wr(8'h01, 16'h0025);
        INPUT_PINS = 6'h21;
        tick(1 + D);
        rd("w1c_pre_status", 8'h03, 16'h0000, 1'b0);
        rd("w1c_pre_state", 8'h00, 16'h0001, 1'b0);
        wr(8'h03, 16'h0020);
        rd("w1c_set_wins", 8'h03, 16'h0020, 1'b1);
        rd("w1c_state", 8'h00, 16'h0021, 1'b1);

        // Register readback and read-only / unmapped addresses.
        for (int i = 0; i < 6; i++) apply_vec(rb_vec[i]);
        rd("rb_status_kept", 8'h03, 16'h0020, 1'b1);

        // Reset in the middle of a debounce.
        INPUT_PINS = 6'h00;
        tick(3);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        rd("mid_rst_status", 8'h03, 16'h0000, 1'b0);
        rd("mid_rst_mask", 8'h04, 16'h0000, 1'b0);
        tick(D + 2);
        rd("mid_rst_state", 8'h00, 16'h0000, 1'b0);
        rd("mid_rst_status2", 8'h03, 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
